// File: rtl/arm_cond_pkg.sv
// Shared ARM condition-code definitions: condition encodings, NZCV bit
// positions and the PC register index.
package arm_cond_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/arm_cond_check.sv
// Combinational ARM condition evaluator: does cond pass against nzcv?
module arm_cond_check
    import arm_cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    // Decode the condition field into a single pass bit.
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;   // NV never executes
        endcase
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// Execute-to-writeback register: condition check, NZCV commit, register-file
// write handshake, PC-write strobe and retired-instruction counter.
module alu_writeback_stage
    import arm_cond_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_n,
    input  logic              ex_z,
    input  logic              ex_c,
    input  logic              ex_v,
    input  logic [3:0]        ex_cond,
    input  logic [3:0]        ex_rd,
    input  logic              ex_wr_en,
    input  logic              ex_set_flags,
    input  logic              flush,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [3:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              pc_write,
    output logic [3:0]        cpsr_nzcv,
    output logic [CNT_W-1:0]  retired_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic              wb_valid_q, wb_valid_d;
    logic [3:0]        wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [3:0]        nzcv_q, nzcv_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic cond_ok;
    logic accept;
    logic exec;
    logic load;

    // Condition is judged against the committed flags, so a flag-setting
    // instruction is visible to the very next one.
    arm_cond_check u_cond (
        .cond (ex_cond),
        .nzcv (nzcv_q),
        .pass (cond_ok)
    );

    assign ex_ready = !flush && (!wb_valid_q || wb_ready);
    assign accept   = ex_valid && ex_ready;
    assign exec     = accept && cond_ok;
    assign load     = exec && ex_wr_en;

    // Next-state: flush kills the entry, a loading accept replaces it,
    // otherwise a consumed entry retires; payload holds while stalled.
    always_comb begin
        wb_valid_d = wb_valid_q;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        nzcv_d     = nzcv_q;
        cnt_d      = cnt_q;
        if (flush) begin
            wb_valid_d = 1'b0;
        end else if (load) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = ex_rd;
            wb_data_d  = ex_result;
        end else if (wb_valid_q && wb_ready) begin
            wb_valid_d = 1'b0;
        end
        if (exec && ex_set_flags) begin
            nzcv_d = {ex_n, ex_z, ex_c, ex_v};
        end
        if (exec) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            nzcv_q     <= '0;
            cnt_q      <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            nzcv_q     <= nzcv_d;
            cnt_q      <= cnt_d;
        end
    end

    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign cpsr_nzcv   = nzcv_q;
    assign retired_cnt = cnt_q;
    assign pc_write    = wb_valid_q && wb_ready && (wb_rd_q == REG_PC);

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed bench for alu_writeback_stage (CNT_W=4 so the counter wrap is reachable).
module tb_alu_writeback_stage;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_valid;
    logic              ex_ready;
    logic [DATA_W-1:0] ex_result;
    logic              ex_n, ex_z, ex_c, ex_v;
    logic [3:0]        ex_cond;
    logic [3:0]        ex_rd;
    logic              ex_wr_en;
    logic              ex_set_flags;
    logic              flush;
    logic              wb_valid;
    logic              wb_ready;
    logic [3:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              pc_write;
    logic [3:0]        cpsr_nzcv;
    logic [CNT_W-1:0]  retired_cnt;

    int total = 0;
    int bad   = 0;

    alu_writeback_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_result    (ex_result),
        .ex_n         (ex_n),
        .ex_z         (ex_z),
        .ex_c         (ex_c),
        .ex_v         (ex_v),
        .ex_cond      (ex_cond),
        .ex_rd        (ex_rd),
        .ex_wr_en     (ex_wr_en),
        .ex_set_flags (ex_set_flags),
        .flush        (flush),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .pc_write     (pc_write),
        .cpsr_nzcv    (cpsr_nzcv),
        .retired_cnt  (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [3:0] rd,
                         input logic wr, input logic sf, input logic [3:0] f,
                         input logic [31:0] res);
        ex_valid     = v;
        ex_cond      = c;
        ex_rd        = rd;
        ex_wr_en     = wr;
        ex_set_flags = sf;
        {ex_n, ex_z, ex_c, ex_v} = f;
        ex_result    = res;
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] pass_mask [4];
    logic [3:0]  flag_set  [4];
    logic [3:0]  exp_cnt;
    logic [15:0] m;

    initial begin
        // Hand-derived pass masks, bit i = condition code i passes.
        flag_set[0] = 4'b0000; pass_mask[0] = 16'h56AA;
        flag_set[1] = 4'b1110; pass_mask[1] = 16'h6A95;
        flag_set[2] = 4'b0011; pass_mask[2] = 16'h6966;
        flag_set[3] = 4'b1001; pass_mask[3] = 16'h565A;

        rst = 1'b1; flush = 1'b0; wb_ready = 1'b1;
        drive(1'b0, 4'hE, 4'd0, 1'b0, 1'b0, 4'b0000, 32'h0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_rd", {28'd0, wb_rd}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_nzcv", {28'd0, cpsr_nzcv}, 32'd0);
        chk("rst_cnt", {28'd0, retired_cnt}, 32'd0);
        chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);

        // First AL write.
        drive(1'b1, 4'hE, 4'd3, 1'b1, 1'b0, 4'b0000, 32'h5);
        tick();
        chk("al_valid", {31'd0, wb_valid}, 32'd1);
        chk("al_rd", {28'd0, wb_rd}, 32'd3);
        chk("al_data", wb_data, 32'd5);
        chk("al_cnt", {28'd0, retired_cnt}, 32'd1);
        chk("al_nzcv", {28'd0, cpsr_nzcv}, 32'd0);

        // A sets Z, B (EQ) writes.
        drive(1'b1, 4'hE, 4'd1, 1'b0, 1'b1, 4'b0100, 32'h0);
        tick();
        chk("a_drain", {31'd0, wb_valid}, 32'd0);
        chk("a_nzcv", {28'd0, cpsr_nzcv}, 32'h4);
        drive(1'b1, 4'h0, 4'd2, 1'b1, 1'b0, 4'b0000, 32'hAA);
        tick();
        chk("eq_valid", {31'd0, wb_valid}, 32'd1);
        chk("eq_rd", {28'd0, wb_rd}, 32'd2);
        chk("eq_data", wb_data, 32'hAA);
        chk("eq_cnt", {28'd0, retired_cnt}, 32'd3);
        // NE fails with Z set.
        drive(1'b1, 4'h1, 4'd5, 1'b1, 1'b0, 4'b0000, 32'hBB);
        tick();
        chk("ne_valid", {31'd0, wb_valid}, 32'd0);
        chk("ne_cnt", {28'd0, retired_cnt}, 32'd3);

        // Stall for 3 cycles with an entry held.
        drive(1'b1, 4'hE, 4'd7, 1'b1, 1'b0, 4'b0000, 32'h77);
        tick();
        chk("st_load", wb_data, 32'h77);
        wb_ready = 1'b0;
        drive(1'b1, 4'hE, 4'd8, 1'b1, 1'b0, 4'b0000, 32'h88);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_ex_ready", {31'd0, ex_ready}, 32'd0);
            tick();
            chk("st_valid", {31'd0, wb_valid}, 32'd1);
            chk("st_data", wb_data, 32'h77);
            chk("st_rd", {28'd0, wb_rd}, 32'd7);
            chk("st_cnt", {28'd0, retired_cnt}, 32'd4);
        end
        wb_ready = 1'b1;
        #1;
        chk("st_release_ready", {31'd0, ex_ready}, 32'd1);
        tick();
        chk("b2b_valid", {31'd0, wb_valid}, 32'd1);
        chk("b2b_rd", {28'd0, wb_rd}, 32'd8);
        chk("b2b_data", wb_data, 32'h88);
        chk("b2b_cnt", {28'd0, retired_cnt}, 32'd5);

        // NV with set_flags: nothing happens.
        drive(1'b1, 4'hF, 4'd9, 1'b1, 1'b1, 4'b1111, 32'h99);
        tick();
        chk("nv_valid", {31'd0, wb_valid}, 32'd0);
        chk("nv_nzcv", {28'd0, cpsr_nzcv}, 32'h4);
        chk("nv_cnt", {28'd0, retired_cnt}, 32'd5);

        // r15 write: pc_write only in the consuming cycle.
        wb_ready = 1'b0;
        drive(1'b1, 4'hE, 4'd15, 1'b1, 1'b0, 4'b0000, 32'h100);
        tick();
        drive(1'b0, 4'hE, 4'd0, 1'b0, 1'b0, 4'b0000, 32'h0);
        chk("pc_held_valid", {31'd0, wb_valid}, 32'd1);
        chk("pc_held_data", wb_data, 32'h100);
        chk("pc_held_pw", {31'd0, pc_write}, 32'd0);
        tick();
        chk("pc_held_pw2", {31'd0, pc_write}, 32'd0);
        wb_ready = 1'b1;
        #1;
        chk("pc_pw", {31'd0, pc_write}, 32'd1);
        tick();
        chk("pc_after_valid", {31'd0, wb_valid}, 32'd0);
        chk("pc_after_pw", {31'd0, pc_write}, 32'd0);
        chk("pc_cnt", {28'd0, retired_cnt}, 32'd6);

        // Flush an r15 entry while stalled.
        drive(1'b1, 4'hE, 4'd15, 1'b1, 1'b0, 4'b0000, 32'h100);
        tick();
        wb_ready = 1'b0;
        flush    = 1'b1;
        drive(1'b1, 4'hE, 4'd4, 1'b1, 1'b1, 4'b1010, 32'h44);
        #1;
        chk("fl_ex_ready", {31'd0, ex_ready}, 32'd0);
        chk("fl_pw", {31'd0, pc_write}, 32'd0);
        tick();
        flush = 1'b0;
        drive(1'b0, 4'hE, 4'd0, 1'b0, 1'b0, 4'b0000, 32'h0);
        wb_ready = 1'b1;
        #1;
        chk("fl_valid", {31'd0, wb_valid}, 32'd0);
        chk("fl_pw_after", {31'd0, pc_write}, 32'd0);
        chk("fl_nzcv", {28'd0, cpsr_nzcv}, 32'h4);
        chk("fl_cnt", {28'd0, retired_cnt}, 32'd7);

        // Condition table over four flag settings.
        exp_cnt = 4'd7;
        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 4'hE, 4'd0, 1'b0, 1'b1, flag_set[s], 32'h0);
            tick();
            exp_cnt = exp_cnt + 4'd1;
            chk("tbl_nzcv", {28'd0, cpsr_nzcv}, {28'd0, flag_set[s]});
            m = pass_mask[s];
            for (int c = 0; c < 16; c++) begin
                drive(1'b1, 4'(c), 4'd1, 1'b1, 1'b0, 4'b0000, 32'(c + 16 * s));
                tick();
                exp_cnt = exp_cnt + {3'd0, m[c]};
                chk($sformatf("tbl_pass_s%0d_c%0d", s, c), {31'd0, wb_valid}, {31'd0, m[c]});
                chk($sformatf("tbl_cnt_s%0d_c%0d", s, c), {28'd0, retired_cnt}, {28'd0, exp_cnt});
            end
        end

        // Reset while holding an r15 entry.
        wb_ready = 1'b0;
        drive(1'b1, 4'hE, 4'd15, 1'b1, 1'b1, 4'b1111, 32'h55);
        tick();
        chk("pre_rst_valid", {31'd0, wb_valid}, 32'd1);
        chk("pre_rst_nzcv", {28'd0, cpsr_nzcv}, 32'hF);
        rst = 1'b1;
        drive(1'b0, 4'hE, 4'd0, 1'b0, 1'b0, 4'b0000, 32'h0);
        tick();
        rst = 1'b0;
        wb_ready = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, wb_valid}, 32'd0);
        chk("mid_rst_rd", {28'd0, wb_rd}, 32'd0);
        chk("mid_rst_data", wb_data, 32'd0);
        chk("mid_rst_nzcv", {28'd0, cpsr_nzcv}, 32'd0);
        chk("mid_rst_cnt", {28'd0, retired_cnt}, 32'd0);
        chk("mid_rst_pw", {31'd0, pc_write}, 32'd0);

        // Counter wrap at 2^CNT_W.
        drive(1'b1, 4'hE, 4'd0, 1'b0, 1'b0, 4'b0000, 32'h0);
        for (int i = 0; i < 15; i++) tick();
        chk("wrap_15", {28'd0, retired_cnt}, 32'd15);
        tick();
        chk("wrap_0", {28'd0, retired_cnt}, 32'd0);
        drive(1'b0, 4'hE, 4'd0, 1'b0, 1'b0, 4'b0000, 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
